// File: rtl/ysyx_041514_mtime_pkg.sv
// Shared system configuration for the CLINT timer: bus widths, register
// addresses and the decoded register-select type.
package ysyx_041514_mtime_pkg;

    localparam int          SYS_ADDR_W        = 32;
    localparam int          SYS_XLEN          = 64;
    localparam logic [31:0] SYS_MTIMECMP_ADDR = 32'h0200_4000;
    localparam logic [31:0] SYS_MTIME_ADDR    = 32'h0200_BFF8;

    // Which timer register an address selects (exact match only)
    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_MTIME    = 2'd1,
        SEL_MTIMECMP = 2'd2
    } mtime_sel_e;

endpackage

// File: rtl/ysyx_041514_mtime.sv
// Machine timer (mtime / mtimecmp) with a tick prescaler, full-word
// register writes, combinational reads and a level timer-pending output.
module ysyx_041514_mtime
    import ysyx_041514_mtime_pkg::*;
#(
    parameter int                ADDR_W        = SYS_ADDR_W,
    parameter int                XLEN          = SYS_XLEN,
    parameter logic [ADDR_W-1:0] MTIMECMP_ADDR = ADDR_W'(SYS_MTIMECMP_ADDR),
    parameter logic [ADDR_W-1:0] MTIME_ADDR    = ADDR_W'(SYS_MTIME_ADDR),
    parameter int                TICK_DIV      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mtime_addr_i,
    input  logic              mtime_write_valid_i,
    input  logic [XLEN-1:0]   mtime_wdata_i,
    output logic [XLEN-1:0]   mtime_rdata_o,
    output logic              mtime_ge_mtime_o
);

    // A one-bit prescaler is kept even for TICK_DIV=1 so the port widths stay legal
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [XLEN-1:0]  r_mtime;
    logic [XLEN-1:0]  r_mtimecmp;
    logic [PRE_W-1:0] r_pre;
    mtime_sel_e       w_sel;
    logic             w_tick;
    logic             w_wr_mtime;
    logic             w_wr_mtimecmp;

    // Address decode shared by the read mux and the write strobes
    always_comb begin
        w_sel = SEL_NONE;
        if (mtime_addr_i == MTIME_ADDR) begin
            w_sel = SEL_MTIME;
        end else if (mtime_addr_i == MTIMECMP_ADDR) begin
            w_sel = SEL_MTIMECMP;
        end
    end

    assign w_tick        = (r_pre == PRE_W'(TICK_DIV - 1));
    assign w_wr_mtime    = mtime_write_valid_i && (w_sel == SEL_MTIME);
    assign w_wr_mtimecmp = mtime_write_valid_i && (w_sel == SEL_MTIMECMP);

    // mtime and its prescaler: a software write wins over the tick and restarts the divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime <= '0;
            r_pre   <= '0;
        end else if (w_wr_mtime) begin
            r_mtime <= mtime_wdata_i;
            r_pre   <= '0;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 1'b1;
            r_pre   <= '0;
        end else begin
            r_pre   <= r_pre + 1'b1;
        end
    end

    // mtimecmp resets to all ones so the timer is not pending out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtimecmp <= '1;
        end else if (w_wr_mtimecmp) begin
            r_mtimecmp <= mtime_wdata_i;
        end
    end

    // Read mux shows current register contents, i.e. the pre-write value in a write cycle
    always_comb begin
        mtime_rdata_o = '0;
        case (w_sel)
            SEL_MTIME:    mtime_rdata_o = r_mtime;
            SEL_MTIMECMP: mtime_rdata_o = r_mtimecmp;
            default:      mtime_rdata_o = '0;
        endcase
    end

    // Level comparison straight from the registers; interrupt enables are applied elsewhere
    assign mtime_ge_mtime_o = (r_mtime >= r_mtimecmp);

endmodule

// File: tb/tb_ysyx_041514_mtime.sv
// Bench for ysyx_041514_mtime: table-driven vectors with a scoreboard,
// one instance per prescaler setting, plus hand-written corner sequences.
module tb_ysyx_041514_mtime;
    import ysyx_041514_mtime_pkg::*;

    localparam logic [31:0] AM   = SYS_MTIME_ADDR;
    localparam logic [31:0] AC   = SYS_MTIMECMP_ADDR;
    localparam logic [31:0] AO   = 32'h0200_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] FE   = 64'hFFFF_FFFF_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [63:0] wd;
    logic [63:0] rd1, rd4;
    logic        ge1, ge4;

    always #5 clk = ~clk;

    ysyx_041514_mtime #(.TICK_DIV(1)) u_dut1 (
        .clk                 (clk),
        .rst                 (rst),
        .mtime_addr_i        (addr),
        .mtime_write_valid_i (we),
        .mtime_wdata_i       (wd),
        .mtime_rdata_o       (rd1),
        .mtime_ge_mtime_o    (ge1)
    );

    ysyx_041514_mtime #(.TICK_DIV(4)) u_dut4 (
        .clk                 (clk),
        .rst                 (rst),
        .mtime_addr_i        (addr),
        .mtime_write_valid_i (we),
        .mtime_wdata_i       (wd),
        .mtime_rdata_o       (rd4),
        .mtime_ge_mtime_o    (ge4)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        we;
        logic [63:0] wd;
        logic [63:0] erd;
        logic        ege;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] erd;
        logic        ege;
    } exp_t;

    vec_t tbl1[$];
    vec_t tbl4[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   sel4   = 1'b0;

    function automatic vec_t mk(logic r, logic [31:0] a, logic w, logic [63:0] d,
                                logic [63:0] e, logic g);
        vec_t v;
        v.rst = r; v.addr = a; v.we = w; v.wd = d; v.erd = e; v.ege = g;
        return v;
    endfunction

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        rst  = v.rst;
        addr = v.addr;
        we   = v.we;
        wd   = v.wd;
        e.id = id; e.erd = v.erd; e.ege = v.ege;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t        e;
        logic [63:0] ard;
        logic        age;
        ard = sel4 ? rd4 : rd1;
        age = sel4 ? ge4 : ge1;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, rdata=%h ge=%0b", tag, ard, age);
        end else begin
            e = sb.pop_front();
            if (ard !== e.erd || age !== e.ege) begin
                n_miss++;
                $display("FAIL %s[%0d]: got rdata=%h ge=%0b, expected rdata=%h ge=%0b",
                         tag, e.id, ard, age, e.erd, e.ege);
            end
        end
    endtask

    // One clocked step: drive after the edge, compare on the falling edge
    task automatic apply(input vec_t v, input int id, input string tag);
        @(posedge clk);
        #1;
        drive(v, id);
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; addr = AM; we = 1'b0; wd = '0;

        // TICK_DIV=1 instance
        tbl1.push_back(mk(0, AM, 0, 0,       0,    0));
        tbl1.push_back(mk(0, AC, 0, 0,       ONES, 0));
        tbl1.push_back(mk(0, AM, 1, 55,      0,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       0,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       1,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       2,    0));
        tbl1.push_back(mk(1, AC, 0, 0,       ONES, 0));
        tbl1.push_back(mk(1, AM, 0, 0,       4,    0));
        tbl1.push_back(mk(1, AC, 1, 10,      ONES, 0));
        tbl1.push_back(mk(1, AC, 0, 0,       10,   0));
        tbl1.push_back(mk(1, AM, 0, 0,       7,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       8,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       9,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       10,   1));
        tbl1.push_back(mk(1, AM, 0, 0,       11,   1));
        tbl1.push_back(mk(1, AC, 1, ONES,    10,   1));
        tbl1.push_back(mk(1, AM, 0, 0,       13,   0));
        tbl1.push_back(mk(1, AM, 1, FE,      14,   0));
        tbl1.push_back(mk(1, AM, 0, 0,       FE,   0));
        tbl1.push_back(mk(1, AM, 0, 0,       ONES, 1));
        tbl1.push_back(mk(1, AM, 0, 0,       0,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       1,    0));
        tbl1.push_back(mk(1, AM, 1, 100,     2,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       100,  0));
        tbl1.push_back(mk(1, AM, 0, 0,       101,  0));
        tbl1.push_back(mk(1, AO, 1, 'h1234,  0,    0));
        tbl1.push_back(mk(1, AO, 0, 0,       0,    0));
        tbl1.push_back(mk(1, AM, 0, 0,       104,  0));
        tbl1.push_back(mk(1, AC, 0, 0,       ONES, 0));
        tbl1.push_back(mk(1, AC, 1, 50,      ONES, 0));
        tbl1.push_back(mk(1, AM, 0, 0,       107,  1));
        tbl1.push_back(mk(1, AM, 1, 10,      108,  1));
        tbl1.push_back(mk(1, AM, 0, 0,       10,   0));
        tbl1.push_back(mk(1, AM, 0, 0,       11,   0));
        tbl1.push_back(mk(1, AM, 0, 999,     12,   0));
        tbl1.push_back(mk(1, AM, 0, 0,       13,   0));

        // TICK_DIV=4 instance
        tbl4.push_back(mk(0, AM, 0, 0, 0,    0));
        tbl4.push_back(mk(0, AC, 1, 1, ONES, 0));
        tbl4.push_back(mk(1, AC, 1, 1, ONES, 0));
        for (int i = 0; i < 3; i++) tbl4.push_back(mk(1, AM, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl4.push_back(mk(1, AM, 0, 0, 1, 1));
        for (int i = 0; i < 2; i++) tbl4.push_back(mk(1, AM, 0, 0, 2, 1));
        tbl4.push_back(mk(0, AM, 0, 0, 0, 0));
        tbl4.push_back(mk(1, AM, 0, 0, 0, 0));
        tbl4.push_back(mk(1, AM, 0, 0, 0, 0));

        sel4 = 1'b0;
        for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i], i, "div1");

        sel4 = 1'b1;
        for (int i = 0; i < tbl4.size(); i++) apply(tbl4[i], i, "div4");

        // mtime write mid-count restarts the prescaler: four reads of 50, then 51
        apply(mk(1, AM, 1, 50, 0, 0), 0, "div4_wr");
        for (int i = 0; i < 4; i++) apply(mk(1, AM, 0, 0, 50, 0), i + 1, "div4_wr");
        apply(mk(1, AM, 0, 0, 51, 0), 5, "div4_wr");

        // Make the timer pending, then reset asynchronously between edges
        apply(mk(1, AC, 1, 0, ONES, 0), 0, "div4_rst");
        apply(mk(1, AM, 0, 0, 51, 1), 1, "div4_rst");
        @(posedge clk);
        #1;
        drive(mk(0, AM, 0, 0, 0, 0), 2);
        #1;
        check("div4_rst_async");
        addr = AC;
        sb.push_back('{3, ONES, 1'b0});
        #1;
        check("div4_rst_async");
        apply(mk(1, AM, 0, 0, 0, 0), 4, "div4_rst");

        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
